// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE row sequencer.
// Holds the sequencer state encoding and the output-column count helper.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_MAC    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_PSUM   = 3'd4,
        ST_DONE   = 3'd5
    } pe_state_e;

    localparam int DEF_FILTER_WIDTH = 3;
    localparam int DEF_IFMAP_WIDTH  = 5;
    localparam int NUM_COLS         = DEF_IFMAP_WIDTH - DEF_FILTER_WIDTH + 1;

    // Valid (no-padding) 1-D convolution produces this many output columns.
    function automatic int num_cols(input int ifmap_width, input int filter_width);
        return ifmap_width - filter_width + 1;
    endfunction

endpackage

// File: rtl/pe_addr_counter.sv
// Saturating up-counter with synchronous load and enable.
// tc flags the last value; the counter holds there rather than wrapping.
module pe_addr_counter #(
    parameter int          WIDTH = 3,
    parameter int unsigned LAST  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    assign tc = (count == LAST_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pe_row_sequencer.sv
// Row-stationary PE sequencer: walks one filter row across one ifmap row,
// driving scratchpad addresses and MAC control, emitting one psum per column.
//
// state  | meaning
// IDLE   | waiting for start handshake, start_ready=1
// CLEAR  | clear accumulator, reset tap index j
// MAC    | FILTER_WIDTH cycles of multiply-accumulate, j = 0..FILTER_WIDTH-1
// SETTLE | one idle cycle for the accumulator pipeline
// PSUM   | present psum for column col until psum_ready
// DONE   | report run complete until done_ready
module pe_row_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
    parameter int IFMAP_WIDTH  = DEF_IFMAP_WIDTH,
    parameter int ADDR_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    output logic [ADDR_WIDTH-1:0] filter_addr,
    output logic [ADDR_WIDTH-1:0] ifmap_addr,
    output logic                  mac_en,
    output logic                  acc_clr,
    output logic                  psum_valid,
    input  logic                  psum_ready,
    output logic [ADDR_WIDTH-1:0] psum_col,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  busy
);

    localparam int COLS = num_cols(IFMAP_WIDTH, FILTER_WIDTH);

    if (IFMAP_WIDTH < FILTER_WIDTH) begin : g_bad_ifmap
        $error("pe_row_sequencer: IFMAP_WIDTH must be >= FILTER_WIDTH");
    end
    if ((1 << ADDR_WIDTH) < IFMAP_WIDTH) begin : g_bad_addr
        $error("pe_row_sequencer: ADDR_WIDTH too narrow for IFMAP_WIDTH");
    end

    pe_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] col, j;
    logic                  col_tc, j_tc;
    logic                  col_load, col_en, j_load, j_en;

    pe_addr_counter #(
        .WIDTH (ADDR_WIDTH),
        .LAST  (COLS - 1)
    ) u_col_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (col_load),
        .load_val ('0),
        .en       (col_en),
        .count    (col),
        .tc       (col_tc)
    );

    pe_addr_counter #(
        .WIDTH (ADDR_WIDTH),
        .LAST  (FILTER_WIDTH - 1)
    ) u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (j_load),
        .load_val ('0),
        .en       (j_en),
        .count    (j),
        .tc       (j_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend only on state and the counter registers, never on inputs.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        filter_addr = '0;
        ifmap_addr  = '0;
        mac_en      = 1'b0;
        acc_clr     = 1'b0;
        psum_valid  = 1'b0;
        psum_col    = '0;
        done_valid  = 1'b0;
        col_load    = 1'b0;
        col_en      = 1'b0;
        j_load      = 1'b0;
        j_en        = 1'b0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    col_load = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_clr = 1'b1;
                j_load  = 1'b1;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en      = 1'b1;
                filter_addr = j;
                ifmap_addr  = col + j;
                j_en        = 1'b1;
                if (j_tc) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_PSUM;
            end
            ST_PSUM: begin
                psum_valid = 1'b1;
                psum_col   = col;
                if (psum_ready) begin
                    if (col_tc) begin
                        state_d = ST_DONE;
                    end else begin
                        col_en  = 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Directed-vector bench for pe_row_sequencer (FILTER_WIDTH=3, IFMAP_WIDTH=5).
// Each vector holds per-cycle inputs and the expected packed output word.
module tb_pe_row_sequencer;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          psum_ready = 1'b0;
    logic          done_ready = 1'b0;
    logic          start_ready, mac_en, acc_clr, psum_valid, done_valid, busy;
    logic [AW-1:0] filter_addr, ifmap_addr, psum_col;

    pe_row_sequencer #(
        .FILTER_WIDTH (3),
        .IFMAP_WIDTH  (5),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .filter_addr (filter_addr),
        .ifmap_addr  (ifmap_addr),
        .mac_en      (mac_en),
        .acc_clr     (acc_clr),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .psum_col    (psum_col),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic        pr;
        logic        dr;
        logic        rs;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;

    always @(posedge clk) begin
        if (psum_valid && psum_ready) hs_cnt <= hs_cnt + 1;
    end

    // {start_ready, busy, mac_en, acc_clr, psum_valid, done_valid, faddr, iaddr, pcol}
    function automatic logic [14:0] pk(input logic sr, input logic bz, input logic me,
                                       input logic ac, input logic pv, input logic dv,
                                       input int fa, input int ia, input int pc);
        return {sr, bz, me, ac, pv, dv, 3'(fa), 3'(ia), 3'(pc)};
    endfunction

    function automatic logic [14:0] w_idle();
        return pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [14:0] w_done();
        return pk(0, 1, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    function automatic logic [14:0] w_psum(input int k);
        return pk(0, 1, 0, 0, 1, 0, 0, 0, k);
    endfunction

    // Unstalled run timeline, r = cycles since the start handshake: each
    // column is CLEAR, MAC x3, SETTLE, PSUM; DONE at r=19, IDLE from r=20.
    function automatic logic [14:0] nominal(input int r);
        int k, p;
        if (r <= 0 || r >= 20) return w_idle();
        if (r == 19) return w_done();
        k = (r - 1) / 6;
        p = (r - 1) % 6;
        case (p)
            0:       return pk(0, 1, 0, 1, 0, 0, 0, 0, 0);
            1, 2, 3: return pk(0, 1, 1, 0, 0, 0, p - 1, k + p - 1, 0);
            4:       return pk(0, 1, 0, 0, 0, 0, 0, 0, 0);
            default: return w_psum(k);
        endcase
    endfunction

    function automatic logic [14:0] observed();
        return {start_ready, busy, mac_en, acc_clr, psum_valid, done_valid,
                filter_addr, ifmap_addr, psum_col};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic pr, input logic dr, input logic rs,
                       input logic [14:0] exp);
        vec_t v;
        v.sv = sv; v.pr = pr; v.dr = dr; v.rs = rs; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start_valid = 1'b0; psum_ready = 1'b1; done_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", 32'(observed()), 32'(w_idle()));
        hs_cnt = 0;
    endtask

    task automatic run_table(input string name, input int exp_hs);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start_valid = tbl[i].sv;
            psum_ready  = tbl[i].pr;
            done_ready  = tbl[i].dr;
            rst         = tbl[i].rs;
            #1;
            check($sformatf("%s_c%0d", name, i), 32'(observed()), 32'(tbl[i].exp));
        end
        check($sformatf("%s_psum_handshakes", name), 32'(hs_cnt), 32'(exp_hs));
        tbl.delete();
    endtask

    initial begin
        // Single run, no backpressure; psum_ready high in IDLE/CLEAR too.
        do_reset();
        for (int c = 0; c <= 22; c++) add(c == 0, 1, 1, 0, nominal(c));
        run_table("nominal", 3);

        // start_valid tied high: back-to-back runs, second start at cycle 20.
        do_reset();
        for (int c = 0; c <= 39; c++) add(1, 1, 1, 0, nominal(c % 20));
        run_table("b2b", 6);

        // psum_ready low at cycles 12..15: column 1 PSUM held 5 cycles.
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c < 12)       add(c == 0, 1, 1, 0, nominal(c));
            else if (c <= 16) add(0, !(c <= 15), 1, 0, w_psum(1));
            else              add(0, 1, 1, 0, nominal(c - 4));
        end
        run_table("psum_stall", 3);

        // done_ready low 19..21 with start_valid held high throughout.
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c < 19)       add(1, 1, 1, 0, nominal(c));
            else if (c <= 22) add(1, 1, !(c <= 21), 0, w_done());
            else              add(1, 1, 1, 0, nominal(c - 23));
        end
        run_table("done_stall", 4);

        // rst during column 1 MAC at j=1 (cycle 9): run discarded.
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c <= 9) add(c == 0, 1, 1, c == 9, nominal(c));
            else        add(0, 1, 1, 0, w_idle());
        end
        run_table("mid_reset", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
